// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store sequencer for a variable-latency data bus; define DMEM_MISALIGN_TRAP_EN to fault on misaligned h/w accesses
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t          state, state_nx;
    logic [31:0]     a, a_in, sd, lane, ext;
    logic [2:0]      f3;
    logic            we, req, bad, expire;
    logic [CW-1:0]   cnt;
    // request decode: legality, optional misalignment trap, address alignment
    always_comb begin
        req = mem_read | mem_write;
`ifdef DMEM_MISALIGN_TRAP_EN
        bad = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (mem_write & ~mem_read & funct3[2])
            | (funct3[1:0] == 2'b01 & addr[0]) | (funct3 == 3'b010 & addr[1:0] != 2'b00);
        a_in = addr;
`else
        bad = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (mem_write & ~mem_read & funct3[2]);
        a_in = funct3[1:0] == 2'b01 ? {addr[31:1], 1'b0} :
               funct3[1:0] == 2'b10 ? {addr[31:2], 2'b00} : addr;
`endif
    end
    // next state, bus drive from latched request, load lane extraction
    always_comb begin
        expire    = cnt == CW'(TIMEOUT - 1);
        state_nx  = state == IDLE ? (req ? (bad ? DONE : BUS) : IDLE) :
                    state == BUS  ? (bus_ack | expire ? DONE : BUS) : IDLE;
        bus_req   = state == BUS;
        bus_we    = bus_req & we;
        bus_addr  = bus_req ? {a[31:2], 2'b00} : 32'd0;
        bus_be    = !bus_req ? 4'b0000 :
                    f3[1:0] == 2'b00 ? 4'b0001 << a[1:0] :
                    f3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
        bus_wdata = !bus_req ? 32'd0 :
                    f3[1:0] == 2'b00 ? {4{sd[7:0]}} :
                    f3[1:0] == 2'b01 ? {2{sd[15:0]}} : sd;
        stall     = ~rst & ((state == IDLE & req) | bus_req);
        lane      = bus_rdata >> {a[1:0], 3'b000};
        ext       = f3[1:0] == 2'b00 ? {{24{~f3[2] & lane[7]}}, lane[7:0]} :
                    f3[1:0] == 2'b01 ? {{16{~f3[2] & lane[15]}}, lane[15:0]} : lane;
    end
    // state, request latch, timeout counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            f3        <= '0;
            sd        <= '0;
            we        <= 1'b0;
            cnt       <= '0;
            load_data <= '0;
            fault     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                a   <= a_in;
                f3  <= funct3;
                sd  <= store_data;
                we  <= mem_write & ~mem_read;
                cnt <= '0;
                if (bad) begin
                    load_data <= '0;
                    fault     <= 1'b1;
                end
            end else if (state == BUS) begin
                if (bus_ack) begin
                    load_data <= ext;
                    fault     <= 1'b0;
                end else if (expire) begin
                    load_data <= '0;
                    fault     <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and randomized checks of dmem_access_ctrl against a behavioural model
module tb_dmem_access_ctrl;
    localparam int TIMEOUT = 16;
    logic        clk = 0, rst = 1;
    logic        mem_read = 0, mem_write = 0, bus_ack = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
    logic        stall, fault, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    int total = 0, bad = 0;

    typedef struct {
        logic        stall0;
        int          nb;
        int          cyc;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic        bwe;
        logic [31:0] wd;
        logic        flt;
        logic [31:0] ld;
    } obs_t;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall),
        .load_data(load_data), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // expected outcome of one access, derived from the access rules directly
    function automatic obs_t model(input logic rd, wr, input logic [2:0] f, input logic [31:0] ad, sd,
                                   input int delay, input logic [31:0] rdata);
        obs_t m;
        int sz;
        logic w, ill, mis, trap;
        logic [31:0] ea;
        longint v;
        m = '{default: 0};
        m.stall0 = 1;
        sz  = 1 << f[1:0];
        w   = wr && !rd;
        ill = (f == 3) || (f >= 6) || (w && f >= 4);
        mis = (ad % sz) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = mis;
        ea = ad;
`else
        trap = 0;
        ea = ad - ad % sz;
`endif
        if (ill || trap) begin
            m.cyc = 1;
            m.flt = 1;
            return m;
        end
        m.baddr = ea - ea % 4;
        m.bwe = w;
        m.be = 4'(((1 << sz) - 1) << (ea % 4));
        for (int i = 0; i < 4; i++) m.wd[8*i +: 8] = sd[8*(i % sz) +: 8];
        if (delay >= TIMEOUT) begin
            m.nb = TIMEOUT;
            m.cyc = TIMEOUT + 1;
            m.flt = 1;
        end else begin
            m.nb = delay + 1;
            m.cyc = delay + 2;
            v = (longint'(rdata) >> (8 * (ea % 4))) % (longint'(1) << (8 * sz));
            if (f < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
            m.ld = 32'(v);
        end
        return m;
    endfunction

    // drive one access; ack on BUS cycle index 'delay' (never if >= TIMEOUT) and record what the DUT did
    task automatic run_access(input logic rd, wr, input logic [2:0] f, input logic [31:0] ad, sd,
                              input int delay, input logic [31:0] rdata, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f; addr = ad; store_data = sd;
        #1 o.stall0 = stall;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin mem_read = 0; mem_write = 0; end
            bus_ack = 0;
            if (bus_req) begin
                if (o.nb == 0) begin
                    o.baddr = bus_addr; o.be = bus_be; o.bwe = bus_we; o.wd = bus_wdata;
                end
                bus_ack = (o.nb == delay);
                bus_rdata = rdata;
                o.nb++;
            end else if (!stall) begin
                o.cyc = c; o.flt = fault; o.ld = load_data;
                break;
            end
        end
        bus_ack = 0;
    endtask

    task automatic test_reset;
        mem_read = 1; funct3 = 3'b010;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin bad++; $display("FAIL reset_bus got req=%b we=%b be=%h addr=%h wd=%h want all 0", bus_req, bus_we, bus_be, bus_addr, bus_wdata); end
        total++; if ({fault, load_data} !== '0) begin bad++; $display("FAIL reset_result got fault=%b ld=%h want 0", fault, load_data); end
        mem_read = 0;
        @(negedge clk) rst = 0;
    endtask

    task automatic test_load_word;
        obs_t o;
        run_access(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, o);
        total++; if (o.be !== 4'b1111 || o.baddr !== 32'h100) begin bad++; $display("FAIL lw_bus got be=%b addr=%h want 1111 00000100", o.be, o.baddr); end
        total++; if (o.ld !== 32'hDEADBEEF || o.flt !== 1'b0) begin bad++; $display("FAIL lw_data got ld=%h fault=%b want deadbeef 0", o.ld, o.flt); end
        total++; if (o.stall0 !== 1'b1 || o.cyc != 2) begin bad++; $display("FAIL lw_stall got stall0=%b cycles=%0d want 1 2", o.stall0, o.cyc); end
    endtask

    task automatic test_load_byte;
        obs_t o;
        run_access(1, 0, 3'b000, 32'h103, 0, 0, 32'h80112233, o);
        total++; if (o.be !== 4'b1000 || o.ld !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got be=%b ld=%h want 1000 ffffff80", o.be, o.ld); end
        run_access(1, 0, 3'b100, 32'h103, 0, 1, 32'h80112233, o);
        total++; if (o.ld !== 32'h00000080 || o.cyc != 3) begin bad++; $display("FAIL lbu got ld=%h cycles=%0d want 00000080 3", o.ld, o.cyc); end
    endtask

    task automatic test_store_half;
        obs_t o;
        run_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 3, 32'h12345678, o);
        total++; if (o.bwe !== 1'b1 || o.be !== 4'b1100) begin bad++; $display("FAIL sh_ctl got we=%b be=%b want 1 1100", o.bwe, o.be); end
        total++; if (o.wd !== 32'hABCDABCD) begin bad++; $display("FAIL sh_wdata got %h want abcdabcd", o.wd); end
        total++; if (o.cyc != 5 || o.flt !== 1'b0) begin bad++; $display("FAIL sh_timing got cycles=%0d fault=%b want 5 0", o.cyc, o.flt); end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_access(1, 0, 3'b010, 32'h300, 0, 1000, 32'hFFFFFFFF, o);
        total++; if (o.nb != TIMEOUT || o.cyc != TIMEOUT + 1) begin bad++; $display("FAIL timeout_len got req_cycles=%0d done=%0d want %0d %0d", o.nb, o.cyc, TIMEOUT, TIMEOUT + 1); end
        total++; if (o.flt !== 1'b1 || o.ld !== 32'd0) begin bad++; $display("FAIL timeout_result got fault=%b ld=%h want 1 0", o.flt, o.ld); end
    endtask

    task automatic test_misalign;
        obs_t o;
        run_access(1, 0, 3'b010, 32'h102, 0, 0, 32'hCAFEF00D, o);
`ifdef DMEM_MISALIGN_TRAP_EN
        total++; if (o.nb != 0 || o.cyc != 1 || o.flt !== 1'b1 || o.ld !== 32'd0) begin bad++; $display("FAIL misalign_trap got req_cycles=%0d done=%0d fault=%b ld=%h want 0 1 1 0", o.nb, o.cyc, o.flt, o.ld); end
`else
        total++; if (o.baddr !== 32'h100 || o.flt !== 1'b0 || o.ld !== 32'hCAFEF00D) begin bad++; $display("FAIL misalign_force got addr=%h fault=%b ld=%h want 00000100 0 cafef00d", o.baddr, o.flt, o.ld); end
`endif
        run_access(0, 1, 3'b100, 32'h0, 0, 0, 0, o);
        total++; if (o.nb != 0 || o.cyc != 1 || o.flt !== 1'b1) begin bad++; $display("FAIL illegal_store got req_cycles=%0d done=%0d fault=%b want 0 1 1", o.nb, o.cyc, o.flt); end
    endtask

    task automatic test_reset_mid_bus;
        int errs = 0;
        @(negedge clk);
        mem_read = 1; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        mem_read = 0;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rstbus_enter got req=%b want 1", bus_req); end
        rst = 1;
        #1;
        total++; if ({bus_req, stall, bus_be, bus_addr} !== '0) begin bad++; $display("FAIL rstbus_async got req=%b stall=%b be=%b addr=%h want 0", bus_req, stall, bus_be, bus_addr); end
        @(negedge clk) rst = 0;
        @(negedge clk) begin bus_ack = 1; bus_rdata = 32'h5A5A5A5A; end
        @(negedge clk) bus_ack = 0;
        for (int i = 0; i < 3; i++) begin
            if ({stall, bus_req, fault, load_data} !== '0) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rstbus_ignore_ack got %0d nonzero cycles stall=%b req=%b fault=%b ld=%h want 0", errs, stall, bus_req, fault, load_data); end
    endtask

    task automatic test_random;
        obs_t o, m;
        logic rd, wr;
        logic [2:0] f;
        logic [31:0] ad, sd, rdata;
        int delay;
        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1;
            f = 3'($urandom);
            ad = $urandom; sd = $urandom; rdata = $urandom;
            delay = $urandom_range(0, TIMEOUT + 2);
            m = model(rd, wr, f, ad, sd, delay, rdata);
            run_access(rd, wr, f, ad, sd, delay, rdata, o);
            total++; if (o.stall0 !== m.stall0 || o.nb != m.nb || o.cyc != m.cyc) begin bad++; $display("FAIL rnd%0d_timing got stall0=%b req_cycles=%0d done=%0d want %b %0d %0d", n, o.stall0, o.nb, o.cyc, m.stall0, m.nb, m.cyc); end
            total++; if (o.baddr !== m.baddr || o.be !== m.be || o.bwe !== m.bwe || o.wd !== m.wd) begin bad++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b wd=%h want %h %b %b %h", n, o.baddr, o.be, o.bwe, o.wd, m.baddr, m.be, m.bwe, m.wd); end
            total++; if (o.flt !== m.flt || o.ld !== m.ld) begin bad++; $display("FAIL rnd%0d_result got fault=%b ld=%h want %b %h", n, o.flt, o.ld, m.flt, m.ld); end
        end
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_load_byte;
        test_store_half;
        test_timeout;
        test_misalign;
        test_reset_mid_bus;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
